// File: rtl/pong_pkg.sv
// Screen geometry, game constants, position type and sequencer states shared by the Pong game path.
// Declarations only: no latency and no flow control.
package pong_pkg;

    localparam int H_ACTIVE     = 640;
    localparam int V_ACTIVE     = 480;
    localparam int PADDLE_W     = 8;
    localparam int PADDLE_H     = 64;
    localparam int PADDLE_STEP  = 4;
    localparam int BALL_SIZE    = 8;
    localparam int BALL_SPEED   = 2;
    localparam int P1_X         = 16;
    localparam int P2_X         = 616;
    localparam int SERVE_FRAMES = 60;
    localparam int SCORE_MAX    = 9;

    typedef logic [9:0]  pos_t;
    typedef logic [10:0] wpos_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_PADDLES,
        ST_BALL,
        ST_COLLIDE,
        ST_SCORE,
        ST_SERVE,
        ST_HALT
    } state_t;

    localparam pos_t PAD_Y_MAX   = pos_t'(V_ACTIVE - PADDLE_H);
    localparam pos_t BALL_Y_MAX  = pos_t'(V_ACTIVE - BALL_SIZE);
    localparam pos_t BALL_X_MISS = pos_t'(H_ACTIVE - BALL_SIZE - BALL_SPEED);
    localparam pos_t PAD_Y_INIT  = pos_t'((V_ACTIVE - PADDLE_H) / 2);
    localparam pos_t BALL_X_INIT = pos_t'((H_ACTIVE - BALL_SIZE) / 2);
    localparam pos_t BALL_Y_INIT = pos_t'((V_ACTIVE - BALL_SIZE) / 2);

    function automatic wpos_t widen(input pos_t p);
        return {1'b0, p};
    endfunction

    // Inclusive left/top, exclusive right/bottom; 11-bit sums so edges near 1023 cannot wrap.
    function automatic logic in_rect(input pos_t x, input pos_t y, input pos_t rx, input pos_t ry,
                                     input int w, input int h);
        return (widen(x) >= widen(rx)) && (widen(x) < widen(rx) + wpos_t'(w)) &&
               (widen(y) >= widen(ry)) && (widen(y) < widen(ry) + wpos_t'(h));
    endfunction

endpackage

// File: rtl/pong_renderer.sv
// Pixel classifier: flags pixels inside either paddle or the ball; one-cycle registered latency.
// No backpressure: a new xpix/ypix pair is accepted every cycle.
module pong_renderer
    import pong_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] xpix,
    input  logic [9:0] ypix,
    input  logic [9:0] pad1_y,
    input  logic [9:0] pad2_y,
    input  logic [9:0] ball_x,
    input  logic [9:0] ball_y,
    output logic       pixval
);

    logic active;
    logic hit;

    always_comb begin
        active = (widen(xpix) < wpos_t'(H_ACTIVE)) && (widen(ypix) < wpos_t'(V_ACTIVE));
        hit    = in_rect(xpix, ypix, pos_t'(P1_X), pad1_y, PADDLE_W, PADDLE_H) ||
                 in_rect(xpix, ypix, pos_t'(P2_X), pad2_y, PADDLE_W, PADDLE_H) ||
                 in_rect(xpix, ypix, ball_x, ball_y, BALL_SIZE, BALL_SIZE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pixval <= 1'b0;
        end else begin
            pixval <= active && hit;
        end
    end

endmodule

// File: rtl/pong_game_scheduler.sv
// Pong game-state sequencer: one paddle/ball/score update per frame, run only in vertical blanking.
// Latency: state settles 7 cycles after the start-of-vblank pixel; pixval 1 cycle; no backpressure.
module pong_game_scheduler
    import pong_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] xpix,
    input  logic [9:0] ypix,
    input  logic       btn_up1,
    input  logic       btn_dn1,
    input  logic       btn_up2,
    input  logic       btn_dn2,
    output logic       pixval,
    output logic       altcolor,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic       game_over
);

    localparam logic [3:0] SMAX       = 4'(SCORE_MAX);
    localparam logic [5:0] SERVE_INIT = 6'(SERVE_FRAMES);

    logic [3:0] btn_meta, btn_sync, btn_lat;
    logic       frame_tick;
    state_t     state;
    logic [5:0] serve_cnt;
    pos_t       pad1_y, pad2_y, ball_x, ball_y;
    logic       dx_right, dy_down;
    pos_t       bx_mv, by_mv;
    logic       dy_mv;
    logic       ovl1, ovl2, hit_l, hit_r, miss_l, miss_r;

    function automatic pos_t move_pad(input pos_t y, input logic up, input logic dn);
        pos_t r;
        r = y;
        if (up && !dn) begin
            r = (y < pos_t'(PADDLE_STEP)) ? '0 : y - pos_t'(PADDLE_STEP);
        end else if (dn && !up) begin
            r = (widen(y) + wpos_t'(PADDLE_STEP) > widen(PAD_Y_MAX)) ? PAD_Y_MAX
                                                                     : y + pos_t'(PADDLE_STEP);
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_meta   <= '0;
            btn_sync   <= '0;
            frame_tick <= 1'b0;
        end else begin
            btn_meta   <= {btn_up1, btn_dn1, btn_up2, btn_dn2};
            btn_sync   <= btn_meta;
            frame_tick <= (xpix == '0) && (ypix == pos_t'(V_ACTIVE));
        end
    end

    // Horizontal motion stops at 0 so a ball leaving the left edge is still seen as a miss.
    always_comb begin
        bx_mv = ball_x;
        by_mv = ball_y;
        dy_mv = dy_down;
        if (dx_right) begin
            bx_mv = ball_x + pos_t'(BALL_SPEED);
        end else begin
            bx_mv = (ball_x < pos_t'(BALL_SPEED)) ? '0 : ball_x - pos_t'(BALL_SPEED);
        end
        if (dy_down) begin
            if (widen(ball_y) + wpos_t'(BALL_SPEED) > widen(BALL_Y_MAX)) begin
                by_mv = BALL_Y_MAX;
                dy_mv = 1'b0;
            end else begin
                by_mv = ball_y + pos_t'(BALL_SPEED);
            end
        end else if (ball_y < pos_t'(BALL_SPEED)) begin
            by_mv = '0;
            dy_mv = 1'b1;
        end else begin
            by_mv = ball_y - pos_t'(BALL_SPEED);
        end
    end

    always_comb begin
        ovl1   = (widen(ball_y) + wpos_t'(BALL_SIZE) > widen(pad1_y)) &&
                 (widen(ball_y) < widen(pad1_y) + wpos_t'(PADDLE_H));
        ovl2   = (widen(ball_y) + wpos_t'(BALL_SIZE) > widen(pad2_y)) &&
                 (widen(ball_y) < widen(pad2_y) + wpos_t'(PADDLE_H));
        hit_l  = !dx_right && ovl1 &&
                 (widen(ball_x) <= wpos_t'(P1_X + PADDLE_W)) &&
                 (widen(ball_x) + wpos_t'(BALL_SIZE) > wpos_t'(P1_X));
        hit_r  = dx_right && ovl2 &&
                 (widen(ball_x) + wpos_t'(BALL_SIZE) >= wpos_t'(P2_X)) &&
                 (widen(ball_x) < wpos_t'(P2_X + PADDLE_W));
        miss_l = !dx_right && (ball_x < pos_t'(BALL_SPEED));
        miss_r = dx_right && (ball_x > BALL_X_MISS);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_SERVE;
            serve_cnt <= SERVE_INIT;
            btn_lat   <= '0;
            pad1_y    <= PAD_Y_INIT;
            pad2_y    <= PAD_Y_INIT;
            ball_x    <= BALL_X_INIT;
            ball_y    <= BALL_Y_INIT;
            dx_right  <= 1'b1;
            dy_down   <= 1'b1;
            score1    <= '0;
            score2    <= '0;
            altcolor  <= 1'b1;
            game_over <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (frame_tick) state <= ST_LATCH;
                end
                ST_LATCH: begin
                    btn_lat <= btn_sync;
                    state   <= ST_PADDLES;
                end
                ST_PADDLES: begin
                    pad1_y <= move_pad(pad1_y, btn_lat[3], btn_lat[2]);
                    pad2_y <= move_pad(pad2_y, btn_lat[1], btn_lat[0]);
                    state  <= ST_BALL;
                end
                ST_BALL: begin
                    ball_x  <= bx_mv;
                    ball_y  <= by_mv;
                    dy_down <= dy_mv;
                    state   <= ST_COLLIDE;
                end
                ST_COLLIDE: begin
                    if (hit_l) begin
                        ball_x   <= pos_t'(P1_X + PADDLE_W);
                        dx_right <= 1'b1;
                    end else if (hit_r) begin
                        ball_x   <= pos_t'(P2_X - BALL_SIZE);
                        dx_right <= 1'b0;
                    end
                    state <= ST_SCORE;
                end
                ST_SCORE: begin
                    if (miss_l || miss_r) begin
                        ball_x    <= BALL_X_INIT;
                        ball_y    <= BALL_Y_INIT;
                        dx_right  <= miss_r;
                        serve_cnt <= SERVE_INIT;
                        altcolor  <= 1'b1;
                        if (miss_l && score2 < SMAX) score2 <= score2 + 4'd1;
                        if (miss_r && score1 < SMAX) score1 <= score1 + 4'd1;
                        if ((miss_l && score2 >= SMAX - 4'd1) || (miss_r && score1 >= SMAX - 4'd1)) begin
                            game_over <= 1'b1;
                            state     <= ST_HALT;
                        end else begin
                            state <= ST_SERVE;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_SERVE: begin
                    if (frame_tick) begin
                        if (serve_cnt <= 6'd1) begin
                            serve_cnt <= '0;
                            altcolor  <= 1'b0;
                            state     <= ST_IDLE;
                        end else begin
                            serve_cnt <= serve_cnt - 6'd1;
                        end
                    end
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    pong_renderer u_renderer (
        .clk    (clk),
        .rst    (rst),
        .xpix   (xpix),
        .ypix   (ypix),
        .pad1_y (pad1_y),
        .pad2_y (pad2_y),
        .ball_x (ball_x),
        .ball_y (ball_y),
        .pixval (pixval)
    );

endmodule

// File: tb/tb_pong_game_scheduler.sv
// Bench for pong_game_scheduler: randomized play against a frame-level game model, with short frames
// (start-of-vblank pixel, blanking wait, then pixel probes) and a few hand-computed literal checks.
module tb_pong_game_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] xpix, ypix;
    logic       btn_up1, btn_dn1, btn_up2, btn_dn2;
    logic       pixval, altcolor, game_over;
    logic [3:0] score1, score2;

    int n_checks = 0;
    int n_fail   = 0;

    // Frame-level game model
    int m_p1, m_p2, m_bx, m_by, m_s1, m_s2, m_serve, m_hits;
    bit m_dxr, m_dyd, m_halt, m_go;

    bit    chk_en = 1'b0;
    bit    pv_on  = 1'b0;
    bit    exp_pix = 1'b0, exp_pix_d = 1'b0;
    string pv_name = "blank", pv_name_d = "blank";

    pong_game_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .xpix      (xpix),
        .ypix      (ypix),
        .btn_up1   (btn_up1),
        .btn_dn1   (btn_dn1),
        .btn_up2   (btn_up2),
        .btn_dn2   (btn_dn2),
        .pixval    (pixval),
        .altcolor  (altcolor),
        .score1    (score1),
        .score2    (score2),
        .game_over (game_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit inr(input int x, input int y, input int rx, input int ry, input int w, input int h);
        return (x >= rx) && (x < rx + w) && (y >= ry) && (y < ry + h);
    endfunction

    function automatic bit m_pix(input int x, input int y);
        if (x >= 640 || y >= 480) return 1'b0;
        return inr(x, y, 16, m_p1, 8, 64) || inr(x, y, 616, m_p2, 8, 64) || inr(x, y, m_bx, m_by, 8, 8);
    endfunction

    function automatic bit vov(input int p);
        return (m_by + 8 > p) && (m_by < p + 64);
    endfunction

    function automatic int pad_move(input int y, input bit u, input bit d);
        if (u && !d) return (y - 4 < 0) ? 0 : y - 4;
        if (d && !u) return (y + 4 > 416) ? 416 : y + 4;
        return y;
    endfunction

    task automatic m_reset();
        m_p1 = 208; m_p2 = 208; m_bx = 316; m_by = 236; m_dxr = 1'b1; m_dyd = 1'b1;
        m_s1 = 0; m_s2 = 0; m_serve = 60; m_halt = 1'b0; m_go = 1'b0; m_hits = 0;
    endtask

    task automatic m_miss(input bit toward_right);
        m_bx = 316; m_by = 236; m_dxr = toward_right; m_serve = 60;
        if (m_s1 >= 9 || m_s2 >= 9) begin
            m_go = 1'b1;
            m_halt = 1'b1;
        end
    endtask

    task automatic m_frame(input bit u1, input bit d1, input bit u2, input bit d2);
        if (m_halt) return;
        if (m_serve > 0) begin
            m_serve--;
            return;
        end
        m_p1 = pad_move(m_p1, u1, d1);
        m_p2 = pad_move(m_p2, u2, d2);
        if (m_dxr) m_bx += 2;
        else m_bx = (m_bx < 2) ? 0 : m_bx - 2;
        if (m_dyd) begin
            if (m_by + 2 > 472) begin m_by = 472; m_dyd = 1'b0; end
            else m_by += 2;
        end else begin
            if (m_by < 2) begin m_by = 0; m_dyd = 1'b1; end
            else m_by -= 2;
        end
        if (!m_dxr && m_bx <= 24 && m_bx + 8 > 16 && vov(m_p1)) begin
            m_bx = 24; m_dxr = 1'b1; m_hits++;
        end else if (m_dxr && m_bx + 8 >= 616 && m_bx < 624 && vov(m_p2)) begin
            m_bx = 608; m_dxr = 1'b0; m_hits++;
        end
        if (!m_dxr && m_bx < 2) begin
            if (m_s2 < 9) m_s2++;
            m_miss(1'b0);
        end else if (m_dxr && m_bx > 630) begin
            if (m_s1 < 9) m_s1++;
            m_miss(1'b1);
        end
    endtask

    initial begin : pix_pipe
        forever begin
            @(posedge clk);
            exp_pix_d = exp_pix;
            pv_name_d = pv_name;
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (pv_on) check({"pixval ", pv_name_d}, int'(pixval), int'(exp_pix_d));
            if (chk_en) begin
                check("score1", int'(score1), m_s1);
                check("score2", int'(score2), m_s2);
                check("altcolor", int'(altcolor), int'(m_halt || m_serve > 0));
                check("game_over", int'(game_over), int'(m_go));
            end
        end
    end

    task automatic cyc(input int x, input int y, input bit e, input string nm);
        xpix = 10'(x); ypix = 10'(y); exp_pix = e; pv_name = nm;
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input int x, input int y);
        cyc(x, y, m_pix(x, y), "model");
    endtask

    task automatic rand_probe();
        int k, x, y;
        k = int'($urandom_range(2));
        if (k == 0) begin
            x = int'($urandom_range(700)); y = int'($urandom_range(520));
        end else if (k == 1) begin
            x = m_bx - 2 + int'($urandom_range(11)); y = m_by - 2 + int'($urandom_range(11));
        end else if ($urandom_range(1) == 0) begin
            x = 14 + int'($urandom_range(11)); y = m_p1 - 2 + int'($urandom_range(67));
        end else begin
            x = 614 + int'($urandom_range(11)); y = m_p2 - 2 + int'($urandom_range(67));
        end
        if (x < 0) x = 0;
        if (y < 0) y = 0;
        probe(x, y);
    endtask

    task automatic frame(input bit u1, input bit d1, input bit u2, input bit d2);
        btn_up1 = u1; btn_dn1 = d1; btn_up2 = u2; btn_dn2 = d2;
        repeat (3) rand_probe();
        chk_en = 1'b0;
        cyc(0, 480, 1'b0, "vblank_start");
        m_frame(u1, d1, u2, d2);
        repeat (7) cyc(700, 500, 1'b0, "blank");
        chk_en = 1'b1;
    endtask

    task automatic pick(input int p, input bit trk, output bit u, output bit d);
        int pc, bc;
        pc = p + 32;
        bc = m_by + 4;
        if ($urandom_range(9) == 0) begin
            u = 1'($urandom_range(1));
            d = 1'($urandom_range(1));
        end else if (trk) begin
            u = bc < pc; d = bc > pc;
        end else begin
            u = bc >= pc; d = bc < pc;
        end
    endtask

    initial begin : driver
        bit u1, d1, u2, d2;
        rst = 1'b1;
        btn_up1 = 1'b0; btn_dn1 = 1'b0; btn_up2 = 1'b0; btn_dn2 = 1'b0;
        xpix = 10'd700; ypix = 10'd500;
        repeat (3) cyc(700, 500, 1'b0, "blank");
        rst = 1'b0;
        m_reset();
        pv_on = 1'b1;
        chk_en = 1'b1;

        check("reset score1", int'(score1), 0);
        check("reset altcolor", int'(altcolor), 1);
        check("reset game_over", int'(game_over), 0);
        cyc(20, 208, 1'b1, "reset pad1 top-left");
        cyc(20, 207, 1'b0, "reset above pad1");
        cyc(316, 236, 1'b1, "reset ball corner");
        cyc(315, 236, 1'b0, "reset left of ball");
        cyc(623, 271, 1'b1, "reset pad2 bottom-right");
        cyc(623, 272, 1'b0, "reset below pad2");
        cyc(20, 480, 1'b0, "vblank line");

        repeat (59) frame(1'b0, 1'b0, 1'b0, 1'b0);
        check("altcolor before last serve tick", int'(altcolor), 1);
        frame(1'b0, 1'b0, 1'b0, 1'b0);
        check("altcolor after 60 serve ticks", int'(altcolor), 0);

        repeat (60) frame(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(20, 0, 1'b1, "pad1 clamped at top");
        cyc(20, 63, 1'b1, "pad1 last row");
        cyc(20, 64, 1'b0, "below clamped pad1");
        cyc(436, 356, 1'b1, "ball after 60 frames");
        cyc(444, 356, 1'b0, "right of ball");
        repeat (4) frame(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(20, 0, 1'b1, "pad1 held with both buttons");
        cyc(20, 64, 1'b0, "pad1 did not move down");

        repeat (30) frame(1'($urandom_range(1)), 1'($urandom_range(1)),
                          1'($urandom_range(1)), 1'($urandom_range(1)));

        // Reset asserted while the sequencer is in its ball-update step.
        chk_en = 1'b0;
        cyc(0, 480, 1'b0, "vblank_start");
        repeat (3) cyc(700, 500, 1'b0, "blank");
        rst = 1'b1;
        repeat (3) cyc(700, 500, 1'b0, "in reset");
        rst = 1'b0;
        m_reset();
        cyc(700, 500, 1'b0, "blank");
        chk_en = 1'b1;
        check("mid-frame reset score2", int'(score2), 0);
        check("mid-frame reset altcolor", int'(altcolor), 1);
        cyc(316, 236, 1'b1, "mid-frame reset ball");
        cyc(20, 208, 1'b1, "mid-frame reset pad1");

        for (int f = 0; f < 6000 && !m_go; f++) begin
            pick(m_p1, m_hits < 3, u1, d1);
            pick(m_p2, m_hits < 3, u2, d2);
            frame(u1, d1, u2, d2);
        end
        check("game finished", int'(game_over), int'(m_go));

        if (m_go) begin
            check("winning score", int'((score1 > score2) ? score1 : score2), 9);
            repeat (5) frame(1'($urandom_range(1)), 1'($urandom_range(1)),
                             1'($urandom_range(1)), 1'($urandom_range(1)));
            check("halt keeps game_over", int'(game_over), 1);
            check("halt keeps altcolor", int'(altcolor), 1);
            cyc(316, 236, 1'b1, "halt ball at centre");
            probe(20, m_p1);
        end

        chk_en = 1'b0;
        cyc(700, 500, 1'b0, "blank");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
